// File: rtl/decode_stage_pkg.sv
// Shared encodings for the decode stage: opcodes, ALU/result-select codes,
// immediate formats and the decode control bundle.
package decode_stage_pkg;

  localparam int WORD_SIZE = 32;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // addi x0,x0,0 -- what fetch injects when it has nothing useful
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101
  } alu_ctl_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_IMM = 2'b11
  } result_src_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_type_e;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src;
    result_src_e result_src;
    alu_ctl_e    alu_ctl;
    logic        illegal;
  } ctrl_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch/writeback-facing bus of the decode stage; master drives D/W side,
// slave (the decode stage) produces the hazard fields and the E-side registers.
interface decode_if #(
  parameter int WORD_SIZE = decode_stage_pkg::WORD_SIZE
);
  logic [31:0]          InstrD;
  logic [WORD_SIZE-1:0] PCD;
  logic [WORD_SIZE-1:0] PCPlus4D;
  logic                 RegWriteW;
  logic [4:0]           RdW;
  logic [WORD_SIZE-1:0] ResultW;
  logic                 FlushE;
  logic [4:0]           Rs1D;
  logic [4:0]           Rs2D;
  logic                 RegWriteE;
  logic                 MemWriteE;
  logic                 JumpE;
  logic                 BranchE;
  logic                 ALUSrcE;
  logic [1:0]           ResultSrcE;
  logic [2:0]           ALUControlE;
  logic [WORD_SIZE-1:0] RD1E;
  logic [WORD_SIZE-1:0] RD2E;
  logic [WORD_SIZE-1:0] ImmExtE;
  logic [WORD_SIZE-1:0] PCE;
  logic [WORD_SIZE-1:0] PCPlus4E;
  logic [4:0]           Rs1E;
  logic [4:0]           Rs2E;
  logic [4:0]           RdE;
  logic                 IllegalE;

  modport master (
    output InstrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW, FlushE,
    input  Rs1D, Rs2D, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
           ResultSrcE, ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
           Rs1E, Rs2E, RdE, IllegalE
  );

  modport slave (
    input  InstrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW, FlushE,
    output Rs1D, Rs2D, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
           ResultSrcE, ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
           Rs1E, Rs2E, RdE, IllegalE
  );
endinterface

// File: rtl/decode_stage_register_file.sv
// Architectural register file: two combinational read ports with same-cycle
// write bypass, one write port, x0 hard-wired to zero, async clear.
module register_file #(
  parameter int WORD_SIZE = 32,
  parameter int REG_COUNT = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           i_ra1,
  input  logic [4:0]           i_ra2,
  output logic [WORD_SIZE-1:0] o_rd1,
  output logic [WORD_SIZE-1:0] o_rd2,
  input  logic                 i_we,
  input  logic [4:0]           i_wa,
  input  logic [WORD_SIZE-1:0] i_wd
);

  logic [WORD_SIZE-1:0] r_regs [REG_COUNT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
    end else if (i_we && (i_wa != 5'd0)) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  // Writeback lands late in the cycle, so forward it to a matching reader
  always_comb begin
    o_rd1 = r_regs[i_ra1];
    if (i_ra1 == 5'd0)                   o_rd1 = '0;
    else if (i_we && (i_wa == i_ra1))    o_rd1 = i_wd;

    o_rd2 = r_regs[i_ra2];
    if (i_ra2 == 5'd0)                   o_rd2 = '0;
    else if (i_we && (i_wa == i_ra2))    o_rd2 = i_wd;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: control decode, immediate extension, register read and the
// D/E pipeline register with flush-to-bubble.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int WORD_SIZE = decode_stage_pkg::WORD_SIZE,
  parameter int REG_COUNT = 32
) (
  input  logic   clk,
  input  logic   rst,
  decode_if.slave bus
);

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic        w_funct7_5;
  alu_ctl_e    w_alu_op;
  logic        w_alu_legal;
  ctrl_t       w_ctrl;
  imm_type_e   w_imm_type;
  logic signed [WORD_SIZE-1:0] w_imm;
  logic [WORD_SIZE-1:0] w_rd1;
  logic [WORD_SIZE-1:0] w_rd2;

  ctrl_t                       r_ctrl_p1;
  logic [WORD_SIZE-1:0]        r_rd1_p1;
  logic [WORD_SIZE-1:0]        r_rd2_p1;
  logic signed [WORD_SIZE-1:0] r_imm_p1;
  logic [WORD_SIZE-1:0]        r_pc_p1;
  logic [WORD_SIZE-1:0]        r_pc4_p1;
  logic [4:0]                  r_rs1_p1;
  logic [4:0]                  r_rs2_p1;
  logic [4:0]                  r_rd_p1;

  function automatic logic signed [WORD_SIZE-1:0] imm_extend(
    input logic [31:0] instr,
    input imm_type_e   imm_type
  );
    logic signed [WORD_SIZE-1:0] imm;
    case (imm_type)
      IMM_S:   imm = WORD_SIZE'($signed({instr[31:25], instr[11:7]}));
      IMM_B:   imm = WORD_SIZE'($signed({instr[31], instr[7], instr[30:25],
                                         instr[11:8], 1'b0}));
      IMM_J:   imm = WORD_SIZE'($signed({instr[31], instr[19:12], instr[20],
                                         instr[30:21], 1'b0}));
      IMM_U:   imm = WORD_SIZE'({instr[31:12], 12'b0});
      default: imm = WORD_SIZE'($signed(instr[31:20]));
    endcase
    return imm;
  endfunction

  assign w_opcode   = bus.InstrD[6:0];
  assign w_funct3   = bus.InstrD[14:12];
  assign w_funct7_5 = bus.InstrD[30];
  assign bus.Rs1D   = bus.InstrD[19:15];
  assign bus.Rs2D   = bus.InstrD[24:20];

  // Only register-register add turns into sub; addi ignores bit 30
  always_comb begin
    w_alu_legal = 1'b1;
    w_alu_op    = ALU_ADD;
    case (w_funct3)
      3'b000:  w_alu_op = ((w_opcode == OP_RTYPE) && w_funct7_5) ? ALU_SUB : ALU_ADD;
      3'b111:  w_alu_op = ALU_AND;
      3'b110:  w_alu_op = ALU_OR;
      3'b100:  w_alu_op = ALU_XOR;
      3'b010:  w_alu_op = ALU_SLT;
      default: w_alu_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_ctrl     = '0;
    w_imm_type = IMM_I;
    case (w_opcode)
      OP_LOAD: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.alu_src    = 1'b1;
        w_ctrl.result_src = RES_MEM;
      end
      OP_STORE: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_imm_type       = IMM_S;
      end
      OP_RTYPE: begin
        if (w_alu_legal) begin
          w_ctrl.reg_write = 1'b1;
          w_ctrl.alu_ctl   = w_alu_op;
        end else begin
          w_ctrl.illegal = 1'b1;
        end
      end
      OP_IALU: begin
        if (w_alu_legal) begin
          w_ctrl.reg_write = 1'b1;
          w_ctrl.alu_src   = 1'b1;
          w_ctrl.alu_ctl   = w_alu_op;
        end else begin
          w_ctrl.illegal = 1'b1;
        end
      end
      OP_BRANCH: begin
        w_ctrl.branch  = 1'b1;
        w_ctrl.alu_ctl = ALU_SUB;
        w_imm_type     = IMM_B;
      end
      OP_JAL: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.jump       = 1'b1;
        w_ctrl.result_src = RES_PC4;
        w_imm_type        = IMM_J;
      end
      OP_LUI: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.result_src = RES_IMM;
        w_imm_type        = IMM_U;
      end
      default: w_ctrl.illegal = 1'b1;
    endcase
  end

  assign w_imm = imm_extend(bus.InstrD, w_imm_type);

  register_file #(
    .WORD_SIZE (WORD_SIZE),
    .REG_COUNT (REG_COUNT)
  ) u_register_file (
    .clk   (clk),
    .rst   (rst),
    .i_ra1 (bus.InstrD[19:15]),
    .i_ra2 (bus.InstrD[24:20]),
    .o_rd1 (w_rd1),
    .o_rd2 (w_rd2),
    .i_we  (bus.RegWriteW),
    .i_wa  (bus.RdW),
    .i_wd  (bus.ResultW)
  );

  // ---- D/E boundary: a flush loads an all-zero bubble ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ctrl_p1 <= '0;
      r_rd1_p1  <= '0;
      r_rd2_p1  <= '0;
      r_imm_p1  <= '0;
      r_pc_p1   <= '0;
      r_pc4_p1  <= '0;
      r_rs1_p1  <= '0;
      r_rs2_p1  <= '0;
      r_rd_p1   <= '0;
    end else if (bus.FlushE) begin
      r_ctrl_p1 <= '0;
      r_rd1_p1  <= '0;
      r_rd2_p1  <= '0;
      r_imm_p1  <= '0;
      r_pc_p1   <= '0;
      r_pc4_p1  <= '0;
      r_rs1_p1  <= '0;
      r_rs2_p1  <= '0;
      r_rd_p1   <= '0;
    end else begin
      r_ctrl_p1 <= w_ctrl;
      r_rd1_p1  <= w_rd1;
      r_rd2_p1  <= w_rd2;
      r_imm_p1  <= w_imm;
      r_pc_p1   <= bus.PCD;
      r_pc4_p1  <= bus.PCPlus4D;
      r_rs1_p1  <= bus.InstrD[19:15];
      r_rs2_p1  <= bus.InstrD[24:20];
      r_rd_p1   <= bus.InstrD[11:7];
    end
  end

  assign bus.RegWriteE   = r_ctrl_p1.reg_write;
  assign bus.MemWriteE   = r_ctrl_p1.mem_write;
  assign bus.JumpE       = r_ctrl_p1.jump;
  assign bus.BranchE     = r_ctrl_p1.branch;
  assign bus.ALUSrcE     = r_ctrl_p1.alu_src;
  assign bus.ResultSrcE  = r_ctrl_p1.result_src;
  assign bus.ALUControlE = r_ctrl_p1.alu_ctl;
  assign bus.IllegalE    = r_ctrl_p1.illegal;
  assign bus.RD1E        = r_rd1_p1;
  assign bus.RD2E        = r_rd2_p1;
  assign bus.ImmExtE     = r_imm_p1;
  assign bus.PCE         = r_pc_p1;
  assign bus.PCPlus4E    = r_pc4_p1;
  assign bus.Rs1E        = r_rs1_p1;
  assign bus.Rs2E        = r_rs2_p1;
  assign bus.RdE         = r_rd_p1;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: decode table plus reset, bypass,
// x0, flush and illegal-opcode sequences, compared through a scoreboard.
module tb_decode_stage;
  import decode_stage_pkg::*;

  // control pack: {RegWrite,MemWrite,Jump,Branch,ALUSrc,ResultSrc[1:0],ALUControl[2:0],Illegal}
  localparam logic [10:0] C_NOP  = 11'b1_0_0_0_1_00_000_0;
  localparam logic [10:0] C_RADD = 11'b1_0_0_0_0_00_000_0;
  localparam logic [10:0] C_ILL  = 11'b0_0_0_0_0_00_000_1;
  localparam logic [10:0] C_LUI  = 11'b1_0_0_0_0_11_000_0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decode_if dif ();

  decode_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  typedef struct {
    logic [10:0] ctl;
    logic [31:0] imm;
    bit          chk_imm;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [14:0] flds;
    logic [63:0] pcs;
    string       name;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [10:0] ctl;
    logic [31:0] imm;
    bit          chk_imm;
    string       name;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[$];
  logic [31:0] mrf[32];
  logic [31:0] pc = 32'h0000_1000;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  // Register-file model including the same-cycle writeback forward
  function automatic logic [31:0] mread(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (dif.RegWriteW && (dif.RdW == a)) return dif.ResultW;
    return mrf[a];
  endfunction

  function automatic logic [10:0] act_ctl();
    return {dif.RegWriteE, dif.MemWriteE, dif.JumpE, dif.BranchE, dif.ALUSrcE,
            dif.ResultSrcE, dif.ALUControlE, dif.IllegalE};
  endfunction

  task automatic set_w(input logic we, input logic [4:0] rd, input logic [31:0] data);
    dif.RegWriteW = we;
    dif.RdW       = rd;
    dif.ResultW   = data;
  endtask

  task automatic add_vec(input logic [31:0] instr, input logic [10:0] ctl,
                         input logic [31:0] imm, input bit chk_imm, input string nm);
    vec_t v;
    v.instr = instr; v.ctl = ctl; v.imm = imm; v.chk_imm = chk_imm; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_ctl"}, 64'(act_ctl()), 64'h0);
    check({nm, "_rd"},  {dif.RD1E, dif.RD2E}, 64'h0);
    check({nm, "_imm"}, 64'(dif.ImmExtE), 64'h0);
    check({nm, "_pc"},  {dif.PCE, dif.PCPlus4E}, 64'h0);
    check({nm, "_fld"}, 64'({dif.Rs1E, dif.Rs2E, dif.RdE}), 64'h0);
  endtask

  task automatic step(input logic [31:0] instr, input logic [10:0] ctl, input logic [31:0] imm,
                      input bit chk_imm, input bit flush, input string nm);
    exp_t e;
    exp_t got;
    dif.InstrD   = instr;
    dif.PCD      = pc;
    dif.PCPlus4D = pc + 32'd4;
    dif.FlushE   = flush;
    #1;
    check({nm, "_rsD"}, 64'({dif.Rs1D, dif.Rs2D}), 64'({instr[19:15], instr[24:20]}));
    if (flush) begin
      e.ctl = '0; e.imm = '0; e.chk_imm = 1'b1; e.rd1 = '0; e.rd2 = '0;
      e.flds = '0; e.pcs = '0;
    end else begin
      e.ctl = ctl; e.imm = imm; e.chk_imm = chk_imm;
      e.rd1 = mread(instr[19:15]);
      e.rd2 = mread(instr[24:20]);
      e.flds = {instr[19:15], instr[24:20], instr[11:7]};
      e.pcs = {pc, pc + 32'd4};
    end
    e.name = nm;
    sb.push_back(e);
    @(posedge clk);
    if (dif.RegWriteW && (dif.RdW != 5'd0)) mrf[dif.RdW] = dif.ResultW;
    #1;
    got = sb.pop_front();
    check({got.name, "_ctl"}, 64'(act_ctl()), 64'(got.ctl));
    if (got.chk_imm) check({got.name, "_imm"}, 64'(dif.ImmExtE), 64'(got.imm));
    check({got.name, "_rd1"}, 64'(dif.RD1E), 64'(got.rd1));
    check({got.name, "_rd2"}, 64'(dif.RD2E), 64'(got.rd2));
    check({got.name, "_fld"}, 64'({dif.Rs1E, dif.Rs2E, dif.RdE}), 64'(got.flds));
    check({got.name, "_pc"},  {dif.PCE, dif.PCPlus4E}, got.pcs);
    pc = pc + 32'd4;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] sw_i;
    for (int i = 0; i < 32; i++) mrf[i] = 32'h0;
    set_w(1'b0, 5'd0, 32'h0);
    dif.InstrD = 32'h0; dif.PCD = 32'h0; dif.PCPlus4D = 32'h0; dif.FlushE = 1'b0;
    sw_i = {7'h7F, 5'd2, 5'd1, 3'b010, 5'b11100, 7'b0100011};

    #1 rst = 1'b0;
    #2 check_zero("por");
    @(posedge clk); #1 rst = 1'b1;

    set_w(1'b1, 5'd1, 32'h1111_1111); step(NOP_INSTR, C_NOP, 32'h0, 1'b1, 1'b0, "pre_x1");
    set_w(1'b1, 5'd2, 32'h2222_2222); step(NOP_INSTR, C_NOP, 32'h0, 1'b1, 1'b0, "pre_x2");
    set_w(1'b1, 5'd3, 32'hFFFF_FFF0); step(NOP_INSTR, C_NOP, 32'h0, 1'b1, 1'b0, "pre_x3");
    set_w(1'b0, 5'd0, 32'h0);

    add_vec(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd4), C_RADD, 32'h0, 1'b0, "add");
    add_vec(enc_r(7'h20, 5'd1, 5'd3, 3'd0, 5'd6), 11'b1_0_0_0_0_00_001_0, 32'h0, 1'b0, "sub");
    add_vec(enc_r(7'h00, 5'd3, 5'd1, 3'd7, 5'd7), 11'b1_0_0_0_0_00_010_0, 32'h0, 1'b0, "and");
    add_vec(enc_r(7'h20, 5'd3, 5'd1, 3'd7, 5'd7), 11'b1_0_0_0_0_00_010_0, 32'h0, 1'b0, "and_f7");
    add_vec(enc_r(7'h00, 5'd2, 5'd3, 3'd6, 5'd8), 11'b1_0_0_0_0_00_011_0, 32'h0, 1'b0, "or");
    add_vec(enc_r(7'h00, 5'd2, 5'd1, 3'd4, 5'd9), 11'b1_0_0_0_0_00_100_0, 32'h0, 1'b0, "xor");
    add_vec(enc_r(7'h00, 5'd1, 5'd3, 3'd2, 5'd10), 11'b1_0_0_0_0_00_101_0, 32'h0, 1'b0, "slt");
    add_vec(enc_r(7'h00, 5'd1, 5'd2, 3'd1, 5'd10), C_ILL, 32'h0, 1'b0, "r_f3_ill");
    add_vec(enc_i(12'hFFB, 5'd1, 3'd0, 5'd8, OP_IALU), C_NOP, 32'hFFFF_FFFB, 1'b1, "addi_neg");
    add_vec(enc_i(12'h407, 5'd2, 3'd0, 5'd8, OP_IALU), C_NOP, 32'h0000_0407, 1'b1, "addi_f7");
    add_vec(enc_i(12'h0FF, 5'd1, 3'd4, 5'd8, OP_IALU), 11'b1_0_0_0_1_00_100_0, 32'h0000_00FF, 1'b1, "xori");
    add_vec(enc_i(12'h800, 5'd3, 3'd2, 5'd8, OP_IALU), 11'b1_0_0_0_1_00_101_0, 32'hFFFF_F800, 1'b1, "slti");
    add_vec(enc_i(12'h7FF, 5'd1, 3'd7, 5'd8, OP_IALU), 11'b1_0_0_0_1_00_010_0, 32'h0000_07FF, 1'b1, "andi");
    add_vec(enc_i(12'h001, 5'd1, 3'd6, 5'd8, OP_IALU), 11'b1_0_0_0_1_00_011_0, 32'h0000_0001, 1'b1, "ori");
    add_vec(enc_i(12'h001, 5'd1, 3'd5, 5'd8, OP_IALU), C_ILL, 32'h0, 1'b0, "i_f3_ill");
    add_vec(enc_i(12'h008, 5'd2, 3'd2, 5'd9, OP_LOAD), 11'b1_0_0_0_1_01_000_0, 32'h0000_0008, 1'b1, "lw");
    add_vec(sw_i, 11'b0_1_0_0_1_00_000_0, 32'hFFFF_FFFC, 1'b1, "sw");
    add_vec(32'hFE00_0EE3, 11'b0_0_0_1_0_00_001_0, 32'hFFFF_FFFC, 1'b1, "beq_m4");
    add_vec({7'h00, 5'd2, 5'd1, 3'd0, 5'b10000, OP_BRANCH}, 11'b0_0_0_1_0_00_001_0, 32'h0000_0010, 1'b1, "beq_p16");
    add_vec(32'h0010_00EF, 11'b1_0_1_0_0_10_000_0, 32'h0000_0800, 1'b1, "jal_p800");
    add_vec(32'hFF9F_F06F, 11'b1_0_1_0_0_10_000_0, 32'hFFFF_FFF8, 1'b1, "jal_m8");
    add_vec(32'hABCD_E0B7, C_LUI, 32'hABCD_E000, 1'b1, "lui");
    add_vec(32'h0000_007F, C_ILL, 32'h0, 1'b0, "ill_7f");
    add_vec(32'h0000_000B, C_ILL, 32'h0, 1'b0, "ill_0b");
    add_vec(NOP_INSTR, C_NOP, 32'h0, 1'b1, "nop");

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].instr, vecs[i].ctl, vecs[i].imm, vecs[i].chk_imm, 1'b0, vecs[i].name);

    // illegal opcode: every control low, flag high
    step(32'h0000_007F, C_ILL, 32'h0, 1'b0, 1'b0, "ill_seq");
    check("ill_flag", 64'(dif.IllegalE), 64'h1);
    check("ill_ctrls", 64'({dif.RegWriteE, dif.MemWriteE, dif.BranchE, dif.JumpE}), 64'h0);

    // same-cycle writeback forward to both read ports
    set_w(1'b1, 5'd5, 32'hDEAD_BEEF);
    step(enc_r(7'h00, 5'd5, 5'd5, 3'd0, 5'd7), C_RADD, 32'h0, 1'b0, 1'b0, "bypass");
    check("bypass_rd1", 64'(dif.RD1E), 64'hDEAD_BEEF);
    check("bypass_rd2", 64'(dif.RD2E), 64'hDEAD_BEEF);
    set_w(1'b0, 5'd0, 32'h0);
    step(enc_r(7'h00, 5'd0, 5'd5, 3'd0, 5'd7), C_RADD, 32'h0, 1'b0, 1'b0, "x5_stored");
    check("x5_stored_rd1", 64'(dif.RD1E), 64'hDEAD_BEEF);

    // writes to x0 are dropped, including from the forward path
    set_w(1'b1, 5'd0, 32'h0000_1234);
    step(enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd7), C_RADD, 32'h0, 1'b0, 1'b0, "x0_wr");
    set_w(1'b0, 5'd0, 32'h0);
    step(enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd7), C_RADD, 32'h0, 1'b0, 1'b0, "x0_rd");
    check("x0_rd1", 64'(dif.RD1E), 64'h0);

    // flush of a store while writeback updates x9
    set_w(1'b1, 5'd9, 32'h9999_9999);
    step(sw_i, 11'b0_1_0_0_1_00_000_0, 32'hFFFF_FFFC, 1'b1, 1'b1, "flush_sw");
    check("flush_memwrite", 64'(dif.MemWriteE), 64'h0);
    set_w(1'b0, 5'd0, 32'h0);
    step(enc_r(7'h00, 5'd0, 5'd9, 3'd0, 5'd10), C_RADD, 32'h0, 1'b0, 1'b0, "after_flush");
    check("flush_x9", 64'(dif.RD1E), 64'h9999_9999);

    // asynchronous reset in mid-cycle with a pending write to x6
    step(32'hABCD_E0B7, C_LUI, 32'hABCD_E000, 1'b1, 1'b0, "lui_pre_rst");
    #2;
    rst = 1'b0;
    set_w(1'b1, 5'd6, 32'h6666_6666);
    dif.InstrD = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd4);
    #1 check_zero("async_rst");
    for (int i = 0; i < 32; i++) mrf[i] = 32'h0;
    @(posedge clk);
    #1 check_zero("rst_held");
    set_w(1'b0, 5'd0, 32'h0);
    rst = 1'b1;
    step(enc_r(7'h00, 5'd6, 5'd5, 3'd0, 5'd11), C_RADD, 32'h0, 1'b0, 1'b0, "post_rst");
    check("post_rst_x5", 64'(dif.RD1E), 64'h0);
    check("post_rst_x6", 64'(dif.RD2E), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, datapath width.
REQ-002 SHALL have parameter REG_COUNT, default 32, architectural registers (x0..x31).
REQ-003 SHALL have one clock and an asynchronous, active-low reset:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have these ports:
- InstrD  input  32  instruction from fetch.
- PCD  input  32  PC of InstrD.
- PCPlus4D  input  32  PCD+4.
- RegWriteW  input  1  writeback enable.
- RdW  input  5  writeback destination.
- ResultW  input  32  writeback data.
- FlushE  input  1  insert bubble into E.
- Rs1D, Rs2D  output  5 each  combinational source fields, for the hazard unit.
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  output  1 each  registered controls.
- ResultSrcE  output  2  00 ALU, 01 memory, 10 PC+4, 11 immediate.
- ALUControlE  output  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E  output  32 each  registered data.
- Rs1E, Rs2E, RdE  output  5 each  registered register fields.
- IllegalE  output  1  registered unsupported-opcode flag.

Function
REQ-005 SHALL decode these opcodes:
- 0000011 lw: RegWrite, ALUSrc, ResultSrc 01, add.
- 0100011 sw: MemWrite, ALUSrc, add.
- 0110011 R-type: RegWrite, ALU op from funct3 plus funct7[5].
- 0010011 I-ALU: RegWrite, ALUSrc, ALU op from funct3; funct7[5] ignored.
- 1100011 beq: Branch, sub.
- 1101111 jal: RegWrite, Jump, ResultSrc 10.
- 0110111 lui: RegWrite, ResultSrc 11.
REQ-006 SHALL map funct3 as 000 add (sub when R-type and funct7[5]=1), 111 and, 110 or, 100 xor, 010 slt; any other funct3 SHALL set Illegal.
REQ-007 SHALL treat any other opcode as Illegal: all controls deasserted and IllegalE=1 on the next edge.
REQ-008 SHALL sign-extend immediates by type:
- I: [31:20].
- S: {[31:25],[11:7]}.
- B: {[31],[7],[30:25],[11:8],0}.
- J: {[31],[19:12],[20],[30:21],0}.
- U: {[31:12], 12'b0}, not sign-extended.
REQ-009 SHALL read two registers combinationally from Rs1D=InstrD[19:15] and Rs2D=InstrD[24:20].
REQ-010 SHALL always read x0 as 0.
REQ-011 SHALL write ResultW to RdW on the rising clk edge when RegWriteW=1 and RdW!=0; writes to x0 SHALL be discarded.
REQ-012 SHALL bypass write data within the cycle: when RegWriteW=1, RdW!=0 and RdW equals a read index, that read port SHALL return ResultW in the same cycle.
REQ-013 SHALL update the D/E register on every rising edge; latency from InstrD to the E outputs SHALL be exactly one cycle.
REQ-014 SHALL, when FlushE=1 at an edge, load all E outputs with 0 (a bubble).
REQ-015 SHALL still perform a coincident register-file write during a FlushE cycle.
REQ-016 SHALL decode the fetch NOP 0x00000013 as addi x0,x0,0: RegWriteE=1, RdE=0, no architectural effect.

Reset
REQ-017 SHALL, while rst=0, asynchronously clear every E output to 0, including IllegalE.
REQ-018 SHALL, while rst=0, asynchronously clear all register-file entries to 0.
REQ-019 SHALL, when rst is asserted mid-operation, discard any pending write; the first post-reset edge SHALL latch the current InstrD normally.

Structure
REQ-020 SHALL take opcode encodings, ALUControl codes, ResultSrc codes, immediate-type codes, NOP and WORD_SIZE from the shared constants file.
REQ-021 SHALL place the register file in one sub-module, register_file: two read ports, one write port, with bypass and reset.
REQ-022 SHALL keep control decode and immediate extension combinational inside decode_stage; total RTL SHALL be 120-400 lines.

Verification
REQ-023 Bench SHALL cover reset: rst=0 mid-run -> all E outputs 0 immediately, without waiting for clk; then x5 reads 0.
REQ-024 Bench SHALL cover bypass: RegWriteW=1, RdW=5, ResultW=0xDEADBEEF, InstrD=add x7,x5,x5 -> next edge RD1E=RD2E=0xDEADBEEF.
REQ-025 Bench SHALL cover x0 protection: write RdW=0, ResultW=0x1234, then read x0 -> RD1E=0.
REQ-026 Bench SHALL cover immediates:
- InstrD=0xFE000EE3 (beq, imm -4) -> ImmExtE=0xFFFFFFFC, BranchE=1, ALUControlE=001.
- InstrD=lui x1,0xABCDE -> ImmExtE=0xABCDE000, ResultSrcE=11.
REQ-027 Bench SHALL cover flush: FlushE=1 with InstrD=sw -> MemWriteE=0 and all E outputs 0 after the edge, while a simultaneous W write to x9 is still visible next cycle.
REQ-028 Bench SHALL cover illegal opcode: InstrD=0x0000007F -> IllegalE=1, RegWriteE=MemWriteE=BranchE=JumpE=0.
